// File: rtl/mux_n_1_scan.sv
// mux_n_1_scan: N:1 channel multiplexer (manual select or round-robin scan) feeding a one-entry output slot.
// Latency: 1 cycle from Data_In/Select_In to MUX_Data_Out.
// Backpressure: valid/ready; the slot holds while Ready_In=0 and reloads on the same cycle it is accepted.
// Optional feature macro: MUX_CHANNEL_MASK_EN adds Channel_Mask_In (1 = channel enabled).
module mux_n_1_scan #(
  parameter int NUM_CHANNELS = 16,
  parameter int DATA_WIDTH   = 8,
  localparam int SEL_WIDTH   = $clog2(NUM_CHANNELS)
) (
  input  logic                             Clock_In,
  input  logic                             Reset_N_In,
  input  logic                             Enable_In,
  input  logic                             Mode_In,
  input  logic [SEL_WIDTH-1:0]             Select_In,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] Data_In,
  input  logic                             Ready_In,
`ifdef MUX_CHANNEL_MASK_EN
  input  logic [NUM_CHANNELS-1:0]          Channel_Mask_In,
`endif
  output logic [DATA_WIDTH-1:0]            MUX_Data_Out,
  output logic                             MUX_Valid_Out,
  output logic [SEL_WIDTH-1:0]             Channel_Out,
  output logic                             Scan_Wrap_Out,
  output logic                             Sel_Error_Out
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  slot_state_t             state_q, state_d;
  logic                    mode_q;
  logic [SEL_WIDTH-1:0]    scan_ptr_q, scan_ptr_d;
  logic [NUM_CHANNELS-1:0] chan_en;

  logic                    mode_rise;
  logic [SEL_WIDTH-1:0]    eff_ptr;
  logic                    sel_legal;
  logic                    scan_found;
  logic                    scan_wrapped;
  logic [SEL_WIDTH-1:0]    scan_idx;
  logic                    pick_ok;
  logic [SEL_WIDTH-1:0]    pick_idx;
  logic [DATA_WIDTH-1:0]   pick_dat;
  logic                    slot_open;
  logic                    load;
  logic                    accept;
  logic                    wrap_d;
  logic                    sel_err_d;

`ifdef MUX_CHANNEL_MASK_EN
  assign chan_en = Channel_Mask_In;
`else
  assign chan_en = '1;
`endif

  // A fresh entry into scan mode restarts the round-robin at channel 0 on that very cycle.
  assign mode_rise = Mode_In && !mode_q;
  assign eff_ptr   = mode_rise ? '0 : scan_ptr_q;

  // Manual select is legal only for an existing, enabled channel.
  always_comb begin
    sel_legal = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (int'(Select_In) == i && chan_en[i]) sel_legal = 1'b1;
    end
  end

  // Scan search: first enabled channel at or after eff_ptr, wrapping past the last channel.
  always_comb begin : scan_search
    int cand;
    cand         = 0;
    scan_found   = 1'b0;
    scan_wrapped = 1'b0;
    scan_idx     = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      cand = int'(eff_ptr) + i;
      if (cand >= NUM_CHANNELS) cand = cand - NUM_CHANNELS;
      if (!scan_found && chan_en[cand]) begin
        scan_found   = 1'b1;
        scan_idx     = SEL_WIDTH'(cand);
        // Wrap when the search crossed the end, or when the pointer steps off the end after this load.
        scan_wrapped = (cand < int'(eff_ptr)) || (cand == NUM_CHANNELS - 1);
      end
    end
  end

  assign pick_ok  = Mode_In ? scan_found : sel_legal;
  assign pick_idx = Mode_In ? scan_idx   : Select_In;

  // Channel data mux with constant slice bases.
  always_comb begin
    pick_dat = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (int'(pick_idx) == k) pick_dat = Data_In[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign slot_open = (state_q == EMPTY) || Ready_In;
  assign load      = Enable_In && slot_open && pick_ok;
  assign accept    = (state_q == FULL) && Ready_In;
  assign wrap_d    = load && Mode_In && scan_wrapped;
  assign sel_err_d = Enable_In && slot_open && !Mode_In && !sel_legal;

  // Slot FSM next state and scan pointer update; a load while FULL implies a same-cycle accept.
  always_comb begin
    state_d    = state_q;
    scan_ptr_d = scan_ptr_q;
    unique case (state_q)
      EMPTY: if (load) state_d = FULL;
      FULL:  if (accept && !load) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (load && Mode_In) begin
      scan_ptr_d = (scan_idx == SEL_WIDTH'(NUM_CHANNELS - 1)) ? '0 : scan_idx + SEL_WIDTH'(1);
    end else if (mode_rise) begin
      scan_ptr_d = '0;
    end
  end

  // State, mode history and scan pointer registers.
  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      state_q    <= EMPTY;
      mode_q     <= 1'b0;
      scan_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= Mode_In;
      scan_ptr_q <= scan_ptr_d;
    end
  end

  // Output slot: data/channel change only on a load, status pulses last one cycle.
  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      MUX_Data_Out  <= '0;
      Channel_Out   <= '0;
      Scan_Wrap_Out <= 1'b0;
      Sel_Error_Out <= 1'b0;
    end else begin
      if (load) begin
        MUX_Data_Out <= pick_dat;
        Channel_Out  <= pick_idx;
      end
      Scan_Wrap_Out <= wrap_d;
      Sel_Error_Out <= sel_err_d;
    end
  end

  assign MUX_Valid_Out = (state_q == FULL);

endmodule

// File: tb/tb_mux_n_1_scan.sv
// tb_mux_n_1_scan: directed bench for mux_n_1_scan (16x8 instance plus a 12-channel instance).
// Latency: outputs checked 1 ns after each rising edge; inputs driven at the same point.
// Backpressure: Ready_In held low for several cycles to exercise slot hold and zero-bubble reload.
module tb_mux_n_1_scan;

  logic         clk;
  logic         rst_n;

  logic         en, mode, rdy;
  logic [3:0]   sel;
  logic [127:0] data;
  logic [15:0]  mask;
  logic [7:0]   dout;
  logic         vld, wrap, err;
  logic [3:0]   chan;

  logic         en12, mode12, rdy12;
  logic [3:0]   sel12;
  logic [95:0]  data12;
  logic [11:0]  mask12;
  logic [7:0]   dout12;
  logic         vld12, wrap12, err12;
  logic [3:0]   chan12;

  int vectors;
  int miscompares;

  mux_n_1_scan #(.NUM_CHANNELS(16), .DATA_WIDTH(8)) dut (
    .Clock_In        (clk),
    .Reset_N_In      (rst_n),
    .Enable_In       (en),
    .Mode_In         (mode),
    .Select_In       (sel),
    .Data_In         (data),
    .Ready_In        (rdy),
`ifdef MUX_CHANNEL_MASK_EN
    .Channel_Mask_In (mask),
`endif
    .MUX_Data_Out    (dout),
    .MUX_Valid_Out   (vld),
    .Channel_Out     (chan),
    .Scan_Wrap_Out   (wrap),
    .Sel_Error_Out   (err)
  );

  mux_n_1_scan #(.NUM_CHANNELS(12), .DATA_WIDTH(8)) dut12 (
    .Clock_In        (clk),
    .Reset_N_In      (rst_n),
    .Enable_In       (en12),
    .Mode_In         (mode12),
    .Select_In       (sel12),
    .Data_In         (data12),
    .Ready_In        (rdy12),
`ifdef MUX_CHANNEL_MASK_EN
    .Channel_Mask_In (mask12),
`endif
    .MUX_Data_Out    (dout12),
    .MUX_Valid_Out   (vld12),
    .Channel_Out     (chan12),
    .Scan_Wrap_Out   (wrap12),
    .Sel_Error_Out   (err12)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach summary (observed running, expected finished)");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill16(input logic [7:0] base);
    for (int k = 0; k < 16; k++) data[k*8 +: 8] = base + 8'(k);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n  = 1'b1;
    en     = 1'b0; mode   = 1'b0; rdy   = 1'b0; sel   = '0;
    en12   = 1'b0; mode12 = 1'b0; rdy12 = 1'b0; sel12 = '0;
    mask   = 16'hFFFF;
    mask12 = 12'hFFF;
    fill16(8'h10);
    for (int k = 0; k < 12; k++) data12[k*8 +: 8] = 8'h10 + 8'(k);

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    chk("rst_data",  32'(dout), 32'h0);
    chk("rst_valid", 32'(vld),  32'h0);
    chk("rst_chan",  32'(chan), 32'h0);
    chk("rst_wrap",  32'(wrap), 32'h0);
    chk("rst_err",   32'(err),  32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Manual select of channel 5
    en = 1'b1; mode = 1'b0; sel = 4'd5; rdy = 1'b1;
    step();
    chk("man5_data",  32'(dout), 32'h15);
    chk("man5_chan",  32'(chan), 32'd5);
    chk("man5_valid", 32'(vld),  32'd1);

    // Enable low while FULL: accept still drains the slot
    en = 1'b0;
    step();
    chk("drain_valid", 32'(vld), 32'd0);

    // Scan 17 cycles: 0..15,0 with one wrap pulse alongside channel 15
    mode = 1'b1; en = 1'b1; rdy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      step();
      chk("scan_chan", 32'(chan), 32'(i % 16));
      chk("scan_data", 32'(dout), 32'(8'h10 + 8'(i % 16)));
      chk("scan_wrap", 32'(wrap), (i == 15) ? 32'd1 : 32'd0);
    end

    // Continue to channel 3
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("scan_to3", 32'(chan), 32'(i));
    end

    // Backpressure for 4 cycles; input data scrambled meanwhile must not leak through
    rdy = 1'b0;
    fill16(8'hE0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("hold_data",  32'(dout), 32'h13);
      chk("hold_chan",  32'(chan), 32'd3);
      chk("hold_valid", 32'(vld),  32'd1);
    end
    fill16(8'h10);
    rdy = 1'b1;
    step();
    chk("bb_chan",  32'(chan), 32'd4);
    chk("bb_data",  32'(dout), 32'h14);
    chk("bb_valid", 32'(vld),  32'd1);

    // Drain, then load channel 9 manually and hold it under backpressure
    en = 1'b0;
    step();
    chk("drain2_valid", 32'(vld), 32'd0);
    mode = 1'b0; sel = 4'd9; en = 1'b1;
    step();
    chk("man9_data", 32'(dout), 32'h19);
    rdy = 1'b0; en = 1'b0;
    step();
    chk("man9_hold", 32'(vld), 32'd1);

    // Asynchronous reset mid-cycle clears everything before the next edge
    #1 rst_n = 1'b0;
    #1;
    chk("arst_data",  32'(dout), 32'h0);
    chk("arst_valid", 32'(vld),  32'h0);
    chk("arst_chan",  32'(chan), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 12-channel instance: out-of-range select is rejected with a one-cycle error
    en12 = 1'b1; mode12 = 1'b0; sel12 = 4'd13; rdy12 = 1'b1;
    step();
    chk("n12_err",   32'(err12), 32'd1);
    chk("n12_valid", 32'(vld12), 32'd0);
    sel12 = 4'd11;
    step();
    chk("n12_err_clr", 32'(err12),  32'd0);
    chk("n12_data",    32'(dout12), 32'h1B);
    chk("n12_chan",    32'(chan12), 32'd11);
    en12 = 1'b0;
    step();
    chk("n12_drain", 32'(vld12), 32'd0);

`ifdef MUX_CHANNEL_MASK_EN
    // Masked scan: 0,5,7,0 with wrap on the return to 0
    mask = 16'h00A1; mode = 1'b1; en = 1'b1; rdy = 1'b1;
    step();
    chk("mask_c0", 32'(chan), 32'd0);
    chk("mask_w0", 32'(wrap), 32'd0);
    step();
    chk("mask_c5", 32'(chan), 32'd5);
    step();
    chk("mask_c7", 32'(chan), 32'd7);
    step();
    chk("mask_c0b", 32'(chan), 32'd0);
    chk("mask_w1",  32'(wrap), 32'd1);
    en = 1'b0;
    step();
    mask = 16'h0000; en = 1'b1;
    step();
    chk("mask0_valid_a", 32'(vld), 32'd0);
    step();
    chk("mask0_valid_b", 32'(vld), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_n_1_scan.md
MUX_N_1_SCAN -- requirements
Module: mux_n_1_scan

Interface
REQ-001 Parameter NUM_CHANNELS, default 16: number of input channels; legal range 2..256.
REQ-002 Parameter DATA_WIDTH, default 8: width of each channel in bits; legal range 1..64.
REQ-003 Derived SEL_WIDTH SHALL equal $clog2(NUM_CHANNELS).
REQ-004 Clock_In  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 Reset_N_In  input  1  reset, asynchronous assert and active-low.
REQ-006 Enable_In  input  1  when 1, permits loading a new sample.
REQ-007 Mode_In  input  1  0 = manual select, 1 = auto scan.
REQ-008 Select_In  input  SEL_WIDTH  channel index used in manual mode.
REQ-009 Data_In  input  NUM_CHANNELS*DATA_WIDTH  flat bus; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 Ready_In  input  1  downstream accepts the output on a cycle where MUX_Valid_Out=1 and Ready_In=1.
REQ-011 MUX_Data_Out  output  DATA_WIDTH  registered sample.
REQ-012 MUX_Valid_Out  output  1  1 while MUX_Data_Out holds an unaccepted sample.
REQ-013 Channel_Out  output  SEL_WIDTH  index of the channel held in MUX_Data_Out.
REQ-014 Scan_Wrap_Out  output  1  one-cycle pulse on the cycle the scan pointer wraps.
REQ-015 Sel_Error_Out  output  1  one-cycle pulse on a rejected manual select.

Function
REQ-016 The output slot SHALL be a two-state FSM: EMPTY (MUX_Valid_Out=0) and FULL (MUX_Valid_Out=1).
REQ-017 A load SHALL occur when Enable_In=1 and (state=EMPTY or Ready_In=1) and a legal channel is available; latency from Data_In/Select_In to MUX_Data_Out SHALL be 1 cycle.
REQ-018 EMPTY->FULL on load; FULL->EMPTY on accept without load; FULL->FULL on accept with same-cycle load (back-to-back, zero bubble); FULL with Ready_In=0 SHALL hold data, channel and valid unchanged.
REQ-019 Manual mode: load channel Select_In; Select_In >= NUM_CHANNELS SHALL not load and SHALL pulse Sel_Error_Out for 1 cycle.
REQ-020 Scan mode: load channel Scan_Ptr, then Scan_Ptr increments; from NUM_CHANNELS-1 it SHALL return to 0 and pulse Scan_Wrap_Out on that load cycle.
REQ-021 Scan_Ptr SHALL advance only on a load; Enable_In=0 or backpressure freezes it.
REQ-022 A registered copy of Mode_In SHALL be kept; on a 0->1 transition Scan_Ptr SHALL be forced to 0 on that cycle so the first scan load is channel 0.
REQ-023 Enable_In=0 while FULL SHALL still allow acceptance, after which the state returns to EMPTY.
REQ-024 Data_In changes while FULL and not accepted SHALL NOT affect MUX_Data_Out.

Reset
REQ-025 While Reset_N_In=0: MUX_Data_Out=0, MUX_Valid_Out=0, Channel_Out=0, Scan_Wrap_Out=0, Sel_Error_Out=0, Scan_Ptr=0, state=EMPTY, registered mode=0.
REQ-026 Reset asserted mid-transfer SHALL discard the held sample immediately; the first load after deassertion SHALL occur no earlier than the first rising edge with Reset_N_In=1.

Configuration
REQ-027 Macro MUX_CHANNEL_MASK_EN defined: add input Channel_Mask_In, width NUM_CHANNELS, where 1 = channel enabled.
REQ-028 With MUX_CHANNEL_MASK_EN, scan mode SHALL skip masked channels, selecting the next enabled index at or after Scan_Ptr (with wrap) within the same cycle; Scan_Wrap_Out SHALL pulse whenever the search passes index NUM_CHANNELS-1.
REQ-029 With MUX_CHANNEL_MASK_EN, an all-zero mask SHALL prevent loads; a manual select of a masked channel SHALL be rejected as in REQ-019.
REQ-030 Without MUX_CHANNEL_MASK_EN, the port SHALL be absent and all channels SHALL be enabled.

Verification (NUM_CHANNELS=16, DATA_WIDTH=8, channel k data = 8'h10+k)
REQ-031 Reset low, then high; manual, Select_In=5, Enable_In=1, Ready_In=1 -> next cycle MUX_Data_Out=8'h15, Channel_Out=5, MUX_Valid_Out=1.
REQ-032 Scan mode, Ready_In=1, 17 cycles -> Channel_Out sequence 0..15,0; Scan_Wrap_Out pulses once, with the load of channel 15.
REQ-033 Scan mode, Ready_In=0 for 4 cycles after loading channel 3 -> outputs hold 8'h13/3; Ready_In=1 -> channel 4 is loaded on the next cycle with no bubble.
REQ-034 Manual, NUM_CHANNELS=12, Select_In=13 -> Sel_Error_Out pulses for 1 cycle; MUX_Valid_Out stays 0.
REQ-035 Reset_N_In pulsed low while FULL with Ready_In=0 -> all outputs are 0 immediately, without waiting for a clock edge.
REQ-036 MUX_CHANNEL_MASK_EN, mask 16'h00A1, scan mode -> Channel_Out sequence 0,5,7,0; all-zero mask -> MUX_Valid_Out stays 0.
